// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the toggle req/ack CDC handshake.
// Define RECV_SYNC3_EN to build the receive side with a 3-flop synchroniser.
package cdc_hs_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam int unsigned WIDTH_D_DEF = 8;

`ifdef RECV_SYNC3_EN
    localparam int unsigned SYNC_DEPTH = 3;
`else
    localparam int unsigned SYNC_DEPTH = 2;
`endif

endpackage

// File: rtl/req_toggle_detect.sv
// Synchronises an asynchronous toggle request and emits a one-cycle pulse per toggle.
// Depth follows cdc_hs_pkg::SYNC_DEPTH (RECV_SYNC3_EN selects 3 flops).
module req_toggle_detect
    import cdc_hs_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic [DEPTH-1:0] sync;
    logic             req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            req_d <= 1'b0;
        end else begin
            sync  <= {sync[DEPTH-2:0], d};
            req_d <= sync[DEPTH-1];
        end
    end

    assign pulse = sync[DEPTH-1] ^ req_d;

endmodule

// File: rtl/recv_control.sv
// Receive end of the toggle req/ack handshake: captures din per request toggle,
// offers it with valid/ready and toggles b_ack on accept. RECV_SYNC3_EN adds a sync stage.
module recv_control
    import cdc_hs_pkg::*;
#(
    parameter int unsigned WIDTH_D = WIDTH_D_DEF
) (
    input  logic               aclk,
    input  logic               arst_n,
    input  logic               a_req,
    input  logic [WIDTH_D-1:0] din,
    output logic [WIDTH_D-1:0] bdata,
    output logic               bvalid,
    input  logic               bready,
    output logic               b_ack,
    output logic               proto_err
);

    state_t state;
    logic   req_pulse;

    req_toggle_detect #(
        .DEPTH(SYNC_DEPTH)
    ) u_req_detect (
        .clk  (aclk),
        .rst_n(arst_n),
        .d    (a_req),
        .pulse(req_pulse)
    );

    // din is quasi-static here: the sync depth guarantees it settled before the pulse.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            bvalid    <= 1'b0;
            bdata     <= '0;
            b_ack     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_pulse) begin
                        bdata  <= din;
                        state  <= ST_VALID;
                        bvalid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    // A toggle while holding a word is consumed and flagged, never replayed.
                    if (req_pulse) begin
                        proto_err <= 1'b1;
                    end
                    if (bready) begin
                        b_ack  <= ~b_ack;
                        state  <= ST_IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    bvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recv_control.sv
// Scoreboard bench for recv_control: sender model pushes expected words, a monitor
// pops them on every accept and checks data, ack toggle and valid drop.
module tb_recv_control;

    logic       aclk;
    logic       arst_n;
    logic       a_req;
    logic [7:0] din;
    logic [7:0] bdata;
    logic       bvalid;
    logic       bready;
    logic       b_ack;
    logic       proto_err;

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [7:0] exp_q[$];
    logic       exp_ack = 1'b0;
    logic       rand_en = 1'b0;

`ifdef RECV_SYNC3_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 3;
`endif

    recv_control #(.WIDTH_D(8)) dut (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .a_req    (a_req),
        .din      (din),
        .bdata    (bdata),
        .bvalid   (bvalid),
        .bready   (bready),
        .b_ack    (b_ack),
        .proto_err(proto_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every accept must deliver the oldest outstanding word and toggle b_ack once.
    initial begin
        forever begin
            @(negedge aclk);
            if (arst_n && bvalid && bready) begin
                if (exp_q.size() == 0) check("extra_word", 32'(bdata), 32'hFFFF_FFFF);
                else check("bdata", 32'(bdata), 32'(exp_q.pop_front()));
                @(posedge aclk);
                #1;
                exp_ack = ~exp_ack;
                check("b_ack_toggle", 32'(b_ack), 32'(exp_ack));
                check("bvalid_drop", 32'(bvalid), 32'd0);
            end
        end
    end

    always @(posedge aclk) begin
        if (rand_en) begin
            #2;
            bready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_bvalid(input string name);
        int unsigned n = 0;
        while (!bvalid && n < 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (!bvalid) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge aclk);
            n++;
        end
        if (exp_q.size() != 0) check(name, exp_q.size(), 32'd0);
        repeat (3) @(posedge aclk);
        #2;
    endtask

    // Sender model: present the word, toggle the request, wait for the acknowledge toggle.
    task automatic send(input logic [7:0] d);
        logic        pre;
        int unsigned n = 0;
        pre = b_ack;
        din = d;
        exp_q.push_back(d);
        a_req = ~a_req;
        while (b_ack === pre && n < 300) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (b_ack === pre) check("send_ack_timeout", 32'(b_ack), 32'(~pre));
        repeat ($urandom_range(0, 3)) @(posedge aclk);
        @(posedge aclk);
        #2;
    endtask

    initial begin
        int unsigned n;
        arst_n = 1'b0;
        a_req  = 1'b0;
        din    = '0;
        bready = 1'b0;
        #12;
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_bdata", 32'(bdata), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        @(posedge aclk);
        #2;
        arst_n = 1'b1;
        repeat (2) @(posedge aclk);

        // Single transfer with zero-wait accept and latency measurement.
        #2;
        bready = 1'b1;
        din    = 8'hA5;
        exp_q.push_back(8'hA5);
        a_req  = ~a_req;
        n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while (!bvalid && n < 10);
        check("latency", n, LAT);
        check("single_bdata", 32'(bdata), 32'hA5);
        wait_drain("single_drain");

        // Backpressure: word held for 10 cycles with b_ack unchanged.
        bready = 1'b0;
        din    = 8'h3C;
        exp_q.push_back(8'h3C);
        a_req  = ~a_req;
        wait_bvalid("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_bdata", 32'(bdata), 32'h3C);
            check("bp_b_ack", 32'(b_ack), 32'(exp_ack));
        end
        @(posedge aclk);
        #2;
        bready = 1'b1;
        wait_drain("bp_drain");
        check("bready_idle_ignored", 32'(bvalid), 32'd0);

        // Violation: two toggles while holding a word.
        bready = 1'b0;
        din    = 8'h5A;
        exp_q.push_back(8'h5A);
        a_req  = ~a_req;
        wait_bvalid("viol_valid_timeout");
        check("no_err_before", 32'(proto_err), 32'd0);
        din   = 8'h77;
        a_req = ~a_req;
        repeat (5) @(posedge aclk);
        #2;
        a_req = ~a_req;
        repeat (6) @(posedge aclk);
        #1;
        check("viol_proto_err", 32'(proto_err), 32'd1);
        check("viol_bdata_kept", 32'(bdata), 32'h5A);
        check("viol_bvalid", 32'(bvalid), 32'd1);
        #1;
        bready = 1'b1;
        wait_drain("viol_drain");
        repeat (6) @(posedge aclk);
        #1;
        check("viol_not_replayed", 32'(bvalid), 32'd0);
        check("viol_sticky", 32'(proto_err), 32'd1);

        // Randomised stream: 0..15 then random words, random backpressure.
        #1;
        rand_en = 1'b1;
        for (int w = 0; w < 16; w++) send(8'(w));
        for (int w = 0; w < 8; w++) send(8'($urandom_range(0, 255)));
        rand_en = 1'b0;
        @(posedge aclk);
        #3;
        wait_drain("rand_drain");
        check("rand_sticky", 32'(proto_err), 32'd1);

        // Reset mid-transfer, then local-only reset with a_req high yields one capture.
        bready = 1'b0;
        din    = 8'h99;
        a_req  = ~a_req;
        wait_bvalid("mid_valid_timeout");
        check("mid_bdata", 32'(bdata), 32'h99);
        @(negedge aclk);
        #2;
        arst_n = 1'b0;
        a_req  = 1'b1;
        din    = 8'hC3;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_b_ack", 32'(b_ack), 32'd0);
        check("mid_rst_bdata", 32'(bdata), 32'd0);
        check("mid_rst_proto_err", 32'(proto_err), 32'd0);
        exp_q.delete();
        exp_ack = 1'b0;
        @(posedge aclk);
        #2;
        arst_n = 1'b1;
        exp_q.push_back(8'hC3);
        bready = 1'b1;
        wait_drain("rst_req_drain");
        repeat (8) @(posedge aclk);
        #1;
        check("rst_req_single", 32'(bvalid), 32'd0);
        check("rst_req_ack", 32'(b_ack), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
